controller_sequencer: RTL and testbench
=======================================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL expose T_STATES, default 6, the fixed number of T-states per instruction cycle.
REQ-002 The block SHALL expose i_clk, input, 1, the system clock; all state updates on the rising edge.
REQ-003 The block SHALL expose i_rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL expose i_program_mode, input, 1, where 1 means the RAM is owned by the manual programming switches and the sequencer is paused.
REQ-005 The block SHALL expose i_opcode, input, 4, the upper nibble of the instruction register.
REQ-006 The block SHALL expose the following 1-bit control outputs: o_pc_inc, o_pc_out, o_pc_load, o_mar_load, o_ram_read, o_ram_write, o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_sub, o_alu_out and o_out_load; all are active-high.
REQ-007 The block SHALL expose o_tstate, output, 6, a one-hot ring-counter value where bit0 is T1 and bit5 is T6.
REQ-008 The block SHALL expose o_halted, output, 1, which is 1 while in the HALTED state.

Function
REQ-009 States SHALL be T1..T6 (one-hot ring) plus HALTED.
REQ-010 Transitions SHALL be T1 to T2 to ... T6 to T1, one per clock, for every opcode.
REQ-011 All control outputs SHALL be combinational decodes of the current state and i_opcode, with no registered delay.
REQ-012 Opcodes: LDA=0000, ADD=0001, SUB=0010, STA=0100, JMP=0101, OUT=1110 and HLT=1111; all other codes SHALL be NOP.
REQ-013 Fetch: T1 SHALL assert o_pc_out and o_mar_load; T2 SHALL assert o_pc_inc; T3 SHALL assert o_ram_read and o_ir_load; fetch is identical for all opcodes.
REQ-014 In T4, LDA, ADD, SUB and STA SHALL assert o_ir_out and o_mar_load; JMP SHALL assert o_ir_out and o_pc_load; OUT SHALL assert o_a_out and o_out_load; NOP and HLT SHALL assert nothing.
REQ-015 In T5, LDA SHALL assert o_ram_read and o_a_load; ADD and SUB SHALL assert o_ram_read and o_b_load; STA SHALL assert o_a_out and o_ram_write; all other opcodes SHALL assert nothing.
REQ-016 In T6, ADD SHALL assert o_alu_out and o_a_load; SUB SHALL assert o_alu_sub, o_alu_out and o_a_load; all other opcodes SHALL assert nothing.
REQ-017 HLT sampled in T4 SHALL cause entry to HALTED on the next edge; HALTED SHALL be held until reset; o_tstate SHALL be 000000 while in HALTED.
REQ-018 In HALTED, all control outputs SHALL be 0 and o_halted SHALL be 1.
REQ-019 At most one bus driver (o_pc_out, o_ram_read, o_ir_out, o_a_out, o_alu_out) SHALL be asserted in any state.
REQ-020 o_ram_read and o_ram_write SHALL never be asserted together.
REQ-021 While i_program_mode=1, all control outputs SHALL be forced to 0 combinationally, and the state SHALL be synchronously forced to T1 on each edge.
REQ-022 If i_program_mode is raised mid-instruction, that instruction SHALL be aborted with no further loads or writes, and the PC is left as already incremented.
REQ-023 When i_program_mode falls, execution SHALL resume with a fresh fetch at T1 on the first edge after it falls.
REQ-024 While in HALTED, i_program_mode SHALL have no effect; only reset exits HALTED.
REQ-025 i_opcode SHALL be treated as a don't-care during T1..T3.

Reset
REQ-026 While i_rst_n=0, the state SHALL be T1 (o_tstate=000001), o_halted SHALL be 0, and all control outputs SHALL follow the T1 decode, forced to 0 if i_program_mode=1.
REQ-027 Reset assertion SHALL take effect immediately, without waiting for a clock edge, from any state including HALTED.
REQ-028 Reset release SHALL take effect at the next rising edge of i_clk, at which point the state advances from T1 to T2.

Verification
REQ-029 Reset, then hold i_program_mode=0 with opcode LDA (0000) for 12 clocks: o_tstate SHALL cycle 000001 through 100000 and repeat; T3 SHALL show o_ram_read=1 and o_ir_load=1; T5 SHALL show o_ram_read=1 and o_a_load=1.
REQ-030 With opcode SUB (0010): T6 SHALL show o_alu_sub=1, o_alu_out=1 and o_a_load=1; with ADD (0001), T6 SHALL show the same except o_alu_sub=0.
REQ-031 With opcode STA (0100): T5 SHALL show o_a_out=1 and o_ram_write=1 with o_ram_read=0; every cycle SHALL satisfy the checks of REQ-019 and REQ-020.
REQ-032 With opcode HLT (1111): after the T4 edge, o_halted=1, o_tstate=000000 and all controls are 0 for 20 clocks; toggling i_program_mode SHALL change nothing; pulsing i_rst_n low SHALL restore o_tstate=000001 asynchronously.
REQ-033 Raise i_program_mode during T5 of LDA: all controls SHALL go to 0 in the same cycle, o_tstate SHALL be 000001 after the next edge, and the state SHALL remain T1 with controls at 0; lowering i_program_mode SHALL restart the fetch at T1.
REQ-034 With opcode JMP (0101): T4 SHALL show o_ir_out=1 and o_pc_load=1; with opcode 1010 (NOP), T4..T6 SHALL show all controls at 0.

Source files
------------

// File: rtl/controller_sequencer.sv
// Microcode sequencer for a SAP-style 8-bit CPU: six-T-state ring plus a sticky
// HALTED state, with all control lines decoded combinationally from state and opcode.
module controller_sequencer #(
  parameter int T_STATES = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_program_mode,
  input  logic [3:0]          i_opcode,
  output logic                o_pc_inc,
  output logic                o_pc_out,
  output logic                o_pc_load,
  output logic                o_mar_load,
  output logic                o_ram_read,
  output logic                o_ram_write,
  output logic                o_ir_load,
  output logic                o_ir_out,
  output logic                o_a_load,
  output logic                o_a_out,
  output logic                o_b_load,
  output logic                o_alu_sub,
  output logic                o_alu_out,
  output logic                o_out_load,
  output logic [T_STATES-1:0] o_tstate,
  output logic                o_halted
);

  typedef enum logic [2:0] {
    T1     = 3'd0,
    T2     = 3'd1,
    T3     = 3'd2,
    T4     = 3'd3,
    T5     = 3'd4,
    T6     = 3'd5,
    HALTED = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state, state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= T1;
    else          state <= state_nxt;
  end

  // Program mode aborts the current instruction, but cannot wake a halted CPU.
  always_comb begin
    state_nxt = state;
    case (state)
      HALTED: state_nxt = HALTED;
      default: begin
        if (i_program_mode)                      state_nxt = T1;
        else if (state == T4 && i_opcode == OP_HLT) state_nxt = HALTED;
        else if (state == T6)                    state_nxt = T1;
        else                                     state_nxt = state_t'(state + 3'd1);
      end
    endcase
  end

  for (genvar i = 0; i < T_STATES; i++) begin : g_tstate
    assign o_tstate[i] = (state == state_t'(3'(i)));
  end

  assign o_halted = (state == HALTED);

  always_comb begin
    o_pc_inc    = 1'b0;
    o_pc_out    = 1'b0;
    o_pc_load   = 1'b0;
    o_mar_load  = 1'b0;
    o_ram_read  = 1'b0;
    o_ram_write = 1'b0;
    o_ir_load   = 1'b0;
    o_ir_out    = 1'b0;
    o_a_load    = 1'b0;
    o_a_out     = 1'b0;
    o_b_load    = 1'b0;
    o_alu_sub   = 1'b0;
    o_alu_out   = 1'b0;
    o_out_load  = 1'b0;
    if (!i_program_mode) begin
      case (state)
        T1: begin o_pc_out = 1'b1; o_mar_load = 1'b1; end
        T2: o_pc_inc = 1'b1;
        T3: begin o_ram_read = 1'b1; o_ir_load = 1'b1; end
        T4: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin o_ir_out = 1'b1; o_mar_load = 1'b1; end
            OP_JMP: begin o_ir_out = 1'b1; o_pc_load = 1'b1; end
            OP_OUT: begin o_a_out = 1'b1; o_out_load = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (i_opcode)
            OP_LDA:         begin o_ram_read = 1'b1; o_a_load = 1'b1; end
            OP_ADD, OP_SUB: begin o_ram_read = 1'b1; o_b_load = 1'b1; end
            OP_STA:         begin o_a_out = 1'b1; o_ram_write = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (i_opcode)
            OP_ADD: begin o_alu_out = 1'b1; o_a_load = 1'b1; end
            OP_SUB: begin o_alu_sub = 1'b1; o_alu_out = 1'b1; o_a_load = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: walks each opcode through T1..T6 against
// hand-written expected control words, then exercises program mode, halt and reset.
module tb_controller_sequencer;

  localparam logic [13:0] PC_INC    = 14'h2000;
  localparam logic [13:0] PC_OUT    = 14'h1000;
  localparam logic [13:0] PC_LOAD   = 14'h0800;
  localparam logic [13:0] MAR_LOAD  = 14'h0400;
  localparam logic [13:0] RAM_READ  = 14'h0200;
  localparam logic [13:0] RAM_WRITE = 14'h0100;
  localparam logic [13:0] IR_LOAD   = 14'h0080;
  localparam logic [13:0] IR_OUT    = 14'h0040;
  localparam logic [13:0] A_LOAD    = 14'h0020;
  localparam logic [13:0] A_OUT     = 14'h0010;
  localparam logic [13:0] B_LOAD    = 14'h0008;
  localparam logic [13:0] ALU_SUB   = 14'h0004;
  localparam logic [13:0] ALU_OUT   = 14'h0002;
  localparam logic [13:0] OUT_LOAD  = 14'h0001;

  logic       clk, rst_n, pm;
  logic [3:0] op;
  logic pc_inc, pc_out, pc_load, mar_load, ram_read, ram_write, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_sub, alu_out, out_load, halted;
  logic [5:0]  tstate;
  logic [13:0] ctrl;
  logic [4:0]  drivers;

  int total = 0;
  int bad   = 0;

  controller_sequencer #(.T_STATES(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_program_mode(pm), .i_opcode(op),
    .o_pc_inc(pc_inc), .o_pc_out(pc_out), .o_pc_load(pc_load), .o_mar_load(mar_load),
    .o_ram_read(ram_read), .o_ram_write(ram_write), .o_ir_load(ir_load), .o_ir_out(ir_out),
    .o_a_load(a_load), .o_a_out(a_out), .o_b_load(b_load), .o_alu_sub(alu_sub),
    .o_alu_out(alu_out), .o_out_load(out_load), .o_tstate(tstate), .o_halted(halted)
  );

  assign ctrl = {pc_inc, pc_out, pc_load, mar_load, ram_read, ram_write, ir_load,
                 ir_out, a_load, a_out, b_load, alu_sub, alu_out, out_load};
  assign drivers = {pc_out, ram_read, ir_out, a_out, alu_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written microcode table: expected control word for opcode op at T(t+1).
  function automatic logic [13:0] exp_ctrl(input logic [3:0] o, input int t);
    logic [13:0] w;
    w = '0;
    case (t)
      0: w = PC_OUT | MAR_LOAD;
      1: w = PC_INC;
      2: w = RAM_READ | IR_LOAD;
      3: case (o)
           4'b0000, 4'b0001, 4'b0010, 4'b0100: w = IR_OUT | MAR_LOAD;
           4'b0101: w = IR_OUT | PC_LOAD;
           4'b1110: w = A_OUT | OUT_LOAD;
           default: w = '0;
         endcase
      4: case (o)
           4'b0000: w = RAM_READ | A_LOAD;
           4'b0001, 4'b0010: w = RAM_READ | B_LOAD;
           4'b0100: w = A_OUT | RAM_WRITE;
           default: w = '0;
         endcase
      5: case (o)
           4'b0001: w = ALU_OUT | A_LOAD;
           4'b0010: w = ALU_SUB | ALU_OUT | A_LOAD;
           default: w = '0;
         endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input logic [3:0] o, input int t);
    string s;
    s = $sformatf("op%0h_T%0d", o, t + 1);
    chk({s, "_tstate"}, 32'(tstate), 32'(6'b1 << t));
    chk({s, "_halted"}, 32'(halted), 32'd0);
    chk({s, "_ctrl"},   32'(ctrl),   32'(exp_ctrl(o, t)));
    chk({s, "_onebus"}, 32'($countones(drivers) <= 1), 32'd1);
    chk({s, "_rdwr"},   32'(ram_read & ram_write), 32'd0);
  endtask

  task automatic run_part(input logic [3:0] o, input int n);
    op = o;
    for (int t = 0; t < n; t++) begin
      #1;
      chk_cycle(o, t);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; pm = 1'b0; op = 4'b0000;
    #3;
    chk("rst_tstate", 32'(tstate), 32'h01);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ctrl",   32'(ctrl),   32'(PC_OUT | MAR_LOAD));
    pm = 1'b1; #1;
    chk("rst_pm_ctrl",   32'(ctrl),   32'd0);
    chk("rst_pm_tstate", 32'(tstate), 32'h01);
    pm = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_hold_tstate", 32'(tstate), 32'h01);
    rst_n = 1'b1;

    // Two back-to-back LDA cycles, then each remaining opcode class.
    run_part(4'b0000, 6);
    run_part(4'b0000, 6);
    run_part(4'b0001, 6);
    run_part(4'b0010, 6);
    run_part(4'b0100, 6);
    run_part(4'b0101, 6);
    run_part(4'b1010, 6);
    run_part(4'b1110, 6);

    // Abort LDA in T5 with program mode.
    run_part(4'b0000, 4);
    #1;
    chk("pm_pre_ctrl", 32'(ctrl), 32'(RAM_READ | A_LOAD));
    pm = 1'b1; #1;
    chk("pm_abort_ctrl",   32'(ctrl),   32'd0);
    chk("pm_abort_tstate", 32'(tstate), 32'h10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("pm_hold_tstate", 32'(tstate), 32'h01);
      chk("pm_hold_ctrl",   32'(ctrl),   32'd0);
    end
    pm = 1'b0;
    run_part(4'b0000, 6);

    // Halt: sticky through program-mode toggles, cleared only by reset.
    run_part(4'b1111, 4);
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  pm = 1'b1;
      if (i == 10) pm = 1'b0;
      if (i == 14) pm = 1'b1;
      if (i == 16) pm = 1'b0;
      #1;
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_tstate", 32'(tstate), 32'h00);
      chk("hlt_ctrl",   32'(ctrl),   32'd0);
      @(posedge clk); @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("hlt_rst_tstate", 32'(tstate), 32'h01);
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_ctrl",   32'(ctrl),   32'(PC_OUT | MAR_LOAD));
    @(negedge clk);
    rst_n = 1'b1;
    run_part(4'b0001, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
